// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch with a DEPTH-entry in-order queue.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_killed counters.
module fetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed,
`endif
  input  logic        id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [31:0]      q_pc    [DEPTH];
  logic [31:0]      q_instr [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] filled;
  logic [DEPTH-1:0] killed;
  ptr_t             alloc;
  ptr_t             fill;
  ptr_t             head;
  cnt_t             used;
  cnt_t             nfilled;
  cnt_t             flushed;
  cnt_t             frees;
  logic             req_fire;
  logic             rsp_ok;
  logic             rsp_kill;
  logic             pop;

  assign imem_req_valid = !rst && (used < FULL) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_stall       = !req_fire && !redirect_valid;
  assign pc_next        = redirect_valid ? {redirect_pc[31:2], 2'b00}
                                         : pc + 32'd4;

  // Only a pending slot can take a response; anything else is dropped.
  assign rsp_ok   = imem_rsp_valid && busy[fill] && !filled[fill];
  assign rsp_kill = rsp_ok && (killed[fill] || redirect_valid);

  assign id_valid = !redirect_valid && busy[head]
                  && filled[head] && !killed[head];
  assign id_pc    = q_pc[head];
  assign id_instr = q_instr[head];
  assign pop      = id_valid && id_ready;

  always_comb begin
    nfilled = '0;
    for (int i = 0; i < DEPTH; i++)
      nfilled = nfilled + cnt_t'(busy[i] & filled[i]);
  end

  assign flushed = redirect_valid ? nfilled : '0;
  assign frees   = cnt_t'(pop) + cnt_t'(rsp_kill) + flushed;

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc  <= '0;
      fill   <= '0;
      head   <= '0;
      used   <= '0;
      busy   <= '0;
      filled <= '0;
      killed <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      used <= used + cnt_t'(req_fire) - frees;
      if (req_fire) begin
        q_pc[alloc]   <= pc;
        busy[alloc]   <= 1'b1;
        filled[alloc] <= 1'b0;
        killed[alloc] <= 1'b0;
        alloc         <= alloc + ptr_t'(1);
      end
      // Filled entries sit between head and fill, so a flush lands head on fill.
      if (redirect_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i] && filled[i]) begin
            busy[i]   <= 1'b0;
            filled[i] <= 1'b0;
          end else if (busy[i]) begin
            killed[i] <= 1'b1;
          end
        end
        head <= fill + ptr_t'(rsp_ok);
      end else if (pop) begin
        busy[head]   <= 1'b0;
        filled[head] <= 1'b0;
        head         <= head + ptr_t'(1);
      end else if (rsp_kill) begin
        head <= head + ptr_t'(1);
      end
      if (rsp_ok) begin
        fill <= fill + ptr_t'(1);
        if (rsp_kill) begin
          busy[fill]   <= 1'b0;
          killed[fill] <= 1'b0;
        end else begin
          q_instr[fill] <= imem_rsp_data;
          filled[fill]  <= 1'b1;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_killed  <= perf_killed + 32'(rsp_kill) + 32'(flushed);
    end
  end
`endif

endmodule
